// File: rtl/scan_ctrl.sv
// Seven-segment scan controller: prescaled digit select plus a round-robin,
// hold-time-protected share of the display value among three requesters.
module scan_ctrl #(
  parameter int DIV_W       = 16,
  parameter int HOLD_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [15:0]       data0,
  input  logic [15:0]       data1,
  input  logic [15:0]       data2,
  output logic [2:0]        ack,
  output logic [1:0]        output_en,
  output logic [15:0]       data,
  output logic              read_mem_en,
  output logic [1:0]        src
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [1:0]        last_q, last_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        src_q, src_d;
  logic [2:0]        ack_q, ack_d;
  logic              valid_q, valid_d;

  logic              tick;
  logic              frame_end;
  logic [1:0]        order [3];
  logic              win_valid;
  logic [1:0]        win_idx;
  logic [15:0]       win_data;

  assign tick      = &presc_q;
  assign frame_end = tick && (sel_q == 2'd3);

  // order[gi] is the requester with (gi+1)-th priority: last+1, last+2, last+3 mod 3
  for (genvar gi = 0; gi < 3; gi++) begin : g_order
    logic [2:0] sum;
    assign sum       = {1'b0, last_q} + 3'(gi + 1);
    assign order[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req[order[k]]) begin
        win_valid = 1'b1;
        win_idx   = order[k];
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      default: win_data = data2;
    endcase
  end

  always_comb begin
    presc_d     = presc_q + DIV_W'(1);
    sel_d       = tick ? sel_q + 2'd1 : sel_q;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    last_d      = last_q;
    data_d      = data_q;
    src_d       = src_q;
    ack_d       = 3'b000;
    valid_d     = valid_q;

    case (state_q)
      S_IDLE, S_READY: begin
        if (win_valid) begin
          state_d     = S_SHOW;
          data_d      = win_data;
          src_d       = win_idx;
          ack_d       = 3'b001 << win_idx;
          last_d      = win_idx;
          frame_cnt_d = 8'd0;
          valid_d     = 1'b1;
        end
      end
      S_SHOW: begin
        // Pending requests are deliberately not looked at until the hold expires
        if (frame_end) begin
          if (frame_cnt_q == 8'(HOLD_FRAMES - 1)) begin
            state_d = S_READY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      sel_q       <= 2'd0;
      frame_cnt_q <= 8'd0;
      last_q      <= 2'd2;
      data_q      <= 16'h0000;
      src_q       <= 2'd3;
      ack_q       <= 3'b000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sel_q       <= sel_d;
      frame_cnt_q <= frame_cnt_d;
      last_q      <= last_d;
      data_q      <= data_d;
      src_q       <= src_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
    end
  end

  assign ack         = ack_q;
  assign output_en   = sel_q;
  assign data        = data_q;
  assign read_mem_en = valid_q;
  assign src         = src_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: a cycle-count based reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_scan_ctrl;

  localparam int DIV_W = 2;
  localparam int HOLD  = 2;
  localparam int P     = 1 << DIV_W;
  localparam int FRAME = 4 * P;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req   = 3'b000;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [15:0] data2 = 16'h0000;
  logic [2:0]  ack;
  logic [1:0]  output_en;
  logic [15:0] data;
  logic        read_mem_en;
  logic [1:0]  src;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  scan_ctrl #(.DIV_W(DIV_W), .HOLD_FRAMES(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .ack         (ack),
    .output_en   (output_en),
    .data        (data),
    .read_mem_en (read_mem_en),
    .src         (src)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since reset gives the scan phase directly; a shown
  // value owes HOLD frame ends before the display may be handed over again.
  int          m_cyc   = 0;
  int          m_last  = 2;
  bit          m_shown = 1'b0;
  int          m_left  = 0;
  logic [15:0] m_data  = 16'h0000;
  int          m_src   = 3;
  logic [2:0]  m_ack   = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   <= 0;
      m_last  <= 2;
      m_shown <= 1'b0;
      m_left  <= 0;
      m_data  <= 16'h0000;
      m_src   <= 3;
      m_ack   <= 3'b000;
    end else begin : step
      automatic int k   = m_cyc + 1;
      automatic bit fe  = ((k % FRAME) == 0);
      automatic int win = -1;
      m_cyc <= k;
      m_ack <= 3'b000;
      if (!m_shown || m_left == 0) begin
        for (int j = 1; j <= 3; j++) begin
          if (win < 0 && req[(m_last + j) % 3]) win = (m_last + j) % 3;
        end
      end
      if (win >= 0) begin
        m_shown <= 1'b1;
        m_left  <= HOLD;
        m_data  <= (win == 0) ? data0 : (win == 1) ? data1 : data2;
        m_src   <= win;
        m_last  <= win;
        m_ack   <= 3'(1 << win);
      end else if (m_shown && m_left > 0 && fe) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("ack", int'(ack), int'(m_ack));
    check("output_en", int'(output_en), (m_cyc / P) % 4);
    check("data", int'(data), int'(m_data));
    check("read_mem_en", int'(read_mem_en), int'(m_shown));
    check("src", int'(src), m_src);
  end

  task automatic wait_ack(input string name, output int who, output int at);
    who = -1;
    at  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        who = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 7;
        at  = cyc;
        $display("grant %s: src=%0d data=%h cycle=%0d", name, who, data, cyc);
        break;
      end
    end
    if (who < 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: no ack within 100 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_sel [16] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    int exp_rr  [4]  = '{0,1,2,0};
    int who, t1, t2, nacks;

    repeat (3) @(negedge clk);
    check("rst_output_en", int'(output_en), 0);
    check("rst_data", int'(data), 0);
    check("rst_read_mem_en", int'(read_mem_en), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_src", int'(src), 3);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("sel_step", int'(output_en), exp_sel[i]);
    end

    data0 = 16'h1234;
    req   = 3'b001;
    wait_ack("first", who, t1);
    check("first_who", who, 0);
    check("first_latency", t1, 17);
    check("first_ack", int'(ack), 1);
    check("first_data", int'(data), 16'h1234);
    check("first_src", int'(src), 0);
    check("first_valid", int'(read_mem_en), 1);
    data1 = 16'hBEEF;
    req   = 3'b010;
    @(negedge clk);
    check("ack_one_cycle", int'(ack), 0);

    wait_ack("held", who, t2);
    check("held_who", who, 1);
    check("hold_min", int'(t2 - t1 >= 18), 1);
    check("hold_max", int'(t2 - t1 <= 32), 1);
    check("held_data", int'(data), 16'hBEEF);
    check("held_src", int'(src), 1);

    req   = 3'b000;
    data2 = 16'hCAFE;
    req   = 3'b100;
    repeat (5) @(negedge clk);
    req   = 3'b000;
    nacks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack != 3'b000) nacks++;
    end
    check("withdraw_no_ack", nacks, 0);
    check("ready_data", int'(data), 16'hBEEF);
    check("ready_src", int'(src), 1);
    check("ready_valid", int'(read_mem_en), 1);

    data0 = 16'h5A5A;
    req   = 3'b001;
    wait_ack("pre_reset", who, t1);
    check("pre_reset_who", who, 0);
    req = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", int'(ack), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_valid", int'(read_mem_en), 0);
    check("midrst_src", int'(src), 3);
    check("midrst_output_en", int'(output_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    data1 = 16'h0F0F;
    req   = 3'b010;
    wait_ack("only_one", who, t1);
    check("only_one_who", who, 1);
    check("only_one_data", int'(data), 16'h0F0F);
    req = 3'b000;

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    data0 = 16'h1111;
    data1 = 16'h2222;
    req   = 3'b011;
    wait_ack("pair", who, t1);
    check("pair_who", who, 0);
    req = 3'b000;

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    data2 = 16'h3333;
    req   = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_ack("rr", who, t1);
      check("rr_order", who, exp_rr[g]);
      if (who >= 0 && who < 3) begin
        req[who] = 1'b0;
        @(negedge clk);
        req[who] = 1'b1;
      end
    end
    req = 3'b000;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
